alu_fifo_param: RTL and testbench

Parametrised successor to the single-ALU write/readback block. Each cycle it computes an ALU result from operands `a`/`b` and an operation selector. When writing is enabled, it pushes that result into a DEPTH-entry FIFO with internal write and read pointers. Results are read back in order through a registered output with valid, full, empty, overflow and result flags. It sits between the operand source (e.g. a bench or sequencer) and any consumer that drains results at its own pace.

---
 rtl/alu_fifo_param.sv | 165 ++++++++++++++++
 tb/tb_alu_fifo_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_fifo_param.sv
// rtl/alu_fifo_param.sv - ALU whose results are pushed into a DEPTH-entry FIFO and read back in order.
// Optional carry/borrow flag logic is enabled by defining ALU_FIFO_CARRY_EN.
module alu_fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr,
  output logic [WIDTH-1:0] dato_salida,
  output logic             valid_out,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             push, pop;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (sel)
      3'b000: begin
`ifdef ALU_FIFO_CARRY_EN
        {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
`else
        alu_res = a + b;
`endif
      end
      3'b001: begin
`ifdef ALU_FIFO_CARRY_EN
        // the extra top bit of the widened difference is the unsigned borrow
        {alu_carry, alu_res} = {1'b0, a} - {1'b0, b};
`else
        alu_res = a - b;
`endif
      end
      3'b010: alu_res = a & b;
      3'b011: alu_res = a | b;
      3'b100: alu_res = a ^ b;
      3'b101: alu_res = ~a;
      3'b110: begin
`ifdef ALU_FIFO_CARRY_EN
        {alu_carry, alu_res} = {a, 1'b0};
`else
        alu_res = {a[WIDTH-2:0], 1'b0};
`endif
      end
      default: begin
        alu_res = a >> 1;
`ifdef ALU_FIFO_CARRY_EN
        alu_carry = a[0];
`endif
      end
    endcase
  end

  // a full FIFO can still take a push when a pop frees the slot on the same edge
  assign push = wr_en && !clr && (!full_q || rd_en);
  assign pop  = rd_en && !clr && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = pop;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d  = wptr_q + AW'(1);
        zero_d  = (alu_res == '0);
        carry_d = alu_carry;
      end else if (wr_en) begin
        ovf_d = 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
        dout_d = mem[rptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign dato_salida = dout_q;
  assign valid_out   = valid_q;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;
  assign overflow    = ovf_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;

endmodule

// File: tb/tb_alu_fifo_param.sv
// tb/tb_alu_fifo_param.sv - directed self-checking bench for alu_fifo_param (WIDTH=8, DEPTH=4).
module tb_alu_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef ALU_FIFO_CARRY_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       sel;
  logic             wr_en, rd_en, clr;
  logic [WIDTH-1:0] dato_salida;
  logic             valid_out, zero_flag, carry_flag, overflow, full, empty;
  logic [AW:0]      count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_v, last_v;

  alu_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
    .wr_en(wr_en), .rd_en(rd_en), .clr(clr),
    .dato_salida(dato_salida), .valid_out(valid_out), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .overflow(overflow), .full(full), .empty(empty),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic c,
                     input logic [7:0] av, input logic [7:0] bv, input logic [2:0] s);
    wr_en = w; rd_en = r; clr = c; a = av; b = bv; sel = s;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    cyc(1'b1, 1'b0, 1'b0, v, 8'd0, 3'b011);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 3'b000);
  endtask

  // a, b, sel, expected result, expected zero_flag, expected carry_flag
  logic [7:0] t_a   [10] = '{8'd255, 8'd3, 8'hF0, 8'hA0, 8'hFF, 8'h5A, 8'h81, 8'h81, 8'd200, 8'h33};
  logic [7:0] t_b   [10] = '{8'd1,   8'd5, 8'h3C, 8'h05, 8'h0F, 8'h00, 8'h00, 8'h00, 8'd100, 8'h33};
  logic [2:0] t_s   [10] = '{3'd0,   3'd1, 3'd2,  3'd3,  3'd4,  3'd5,  3'd6,  3'd7,  3'd0,   3'd4};
  logic [7:0] t_r   [10] = '{8'd0,   8'd254, 8'h30, 8'hA5, 8'hF0, 8'hA5, 8'h02, 8'h40, 8'd44, 8'h00};
  logic       t_z   [10] = '{1'b1,   1'b0, 1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,   1'b1};
  logic       t_c   [10] = '{CE,     CE,   1'b0,  1'b0,  1'b0,  1'b0,  CE,    CE,    CE,     1'b0};

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dato", dato_salida, 0);
    check("rst_valid", valid_out, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 8'(74 - k), 8'(k), 3'b000);
    check("t1_full", full, 1);
    check("t1_count", count, 4);
    for (int k = 0; k < 4; k++) begin
      pop();
      check("t1_dato", dato_salida, 74);
      check("t1_valid", valid_out, 1);
    end
    check("t1_empty", empty, 1);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'b000);
    check("t1_idle_valid", valid_out, 0);

    for (int v = 1; v <= 5; v++) begin
      push(8'(v));
      if (v == 4) check("t2_full4", full, 1);
    end
    check("t2_ovf", overflow, 1);
    check("t2_count", count, 4);
    for (int v = 1; v <= 4; v++) begin
      pop();
      check("t2_pop", dato_salida, v);
    end
    check("t2_empty", empty, 1);
    check("t2_ovf_sticky", overflow, 1);
    push(8'd7);
    push(8'd8);
    cyc(1'b1, 1'b1, 1'b1, 8'd9, 8'd0, 3'b011);
    check("t2_clr_ovf", overflow, 0);
    check("t2_clr_count", count, 0);
    check("t2_clr_empty", empty, 1);
    check("t2_clr_valid", valid_out, 0);
    check("t2_clr_dato", dato_salida, 4);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, t_a[i], t_b[i], t_s[i]);
      check("alu_zero", zero_flag, t_z[i]);
      check("alu_carry", carry_flag, t_c[i]);
      pop();
      check("alu_res", dato_salida, t_r[i]);
      check("alu_valid", valid_out, 1);
    end

    for (int v = 10; v <= 13; v++) begin
      push(8'(v));
      q.push_back(8'(v));
    end
    exp_v = q.pop_front();
    q.push_back(8'd9);
    cyc(1'b1, 1'b1, 1'b0, 8'd9, 8'd0, 3'b011);
    check("t4_pp_dato", dato_salida, exp_v);
    check("t4_pp_count", count, 4);
    check("t4_pp_ovf", overflow, 0);
    check("t4_pp_full", full, 1);
    for (int i = 0; i < 20; i++) begin
      exp_v = q.pop_front();
      q.push_back(8'(100 + i));
      cyc(1'b1, 1'b1, 1'b0, 8'(100 + i), 8'd0, 3'b011);
      check("t4_wrap", dato_salida, exp_v);
    end
    check("t4_wrap_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      exp_v = q.pop_front();
      pop();
      check("t4_drain", dato_salida, exp_v);
    end
    last_v = exp_v;
    check("t4_empty", empty, 1);

    cyc(1'b1, 1'b1, 1'b0, 8'd55, 8'd0, 3'b011);
    check("t5_valid", valid_out, 0);
    check("t5_count", count, 1);
    check("t5_hold", dato_salida, last_v);
    pop();
    check("t5_dato", dato_salida, 55);
    check("t5_valid2", valid_out, 1);
    pop();
    check("t5_empty_valid", valid_out, 0);
    check("t5_empty_hold", dato_salida, 55);

    for (int v = 1; v <= 4; v++) push(8'(20 + v));
    pop();
    check("t6_pre_dato", dato_salida, 21);
    check("t6_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    check("t6_dato", dato_salida, 0);
    check("t6_valid", valid_out, 0);
    #1;
    rst_n = 1'b1;
    pop();
    check("t6_post_valid", valid_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
